// File: rtl/wishbone_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone B4 classic target among NUM_REQ controllers.
// Optional stb-without-ack timeout/abort enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter_rr #(
    parameter int NUM_REQ   = 4,
    parameter int DAT_WIDTH = 8,
    parameter int ADR_WIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             m_cyc_i,
    input  logic [NUM_REQ-1:0]             m_stb_i,
    input  logic [NUM_REQ-1:0]             m_we_i,
    input  logic [NUM_REQ*ADR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_REQ*DAT_WIDTH-1:0]   m_dat_i,
    output logic [DAT_WIDTH-1:0]           m_dat_o,
    output logic [NUM_REQ-1:0]             m_ack_o,
    output logic [NUM_REQ-1:0]             m_err_o,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [ADR_WIDTH-1:0]           s_adr_o,
    output logic [DAT_WIDTH-1:0]           s_dat_o,
    input  logic [DAT_WIDTH-1:0]           s_dat_i,
    input  logic                           s_ack_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2) begin : g_bad_cfg
        $error("wishbone_arbiter_rr: unsupported NUM_REQ/TIMEOUT");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
        , ST_ABORT = 2'd2
`endif
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IW-1:0]      r_last;

    logic               w_busy;
    logic               w_cyc;
    logic               w_stb;
    logic               w_found;
    logic [IW-1:0]      w_next;
    logic [IW-1:0]      w_cand;
    logic [IW-1:0]      w_sel;

    // Pick the first requester with cyc high, scanning upward from last+1.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IW'((int'(r_last) + i) % NUM_REQ);
            if (!w_found && m_cyc_i[w_cand]) begin
                w_found = 1'b1;
                w_next  = w_cand;
            end
        end
    end

    assign w_busy  = (r_state == ST_BUSY);
    assign w_sel   = w_busy ? r_last : '0;
    assign w_cyc   = w_busy & m_cyc_i[r_last];
    assign w_stb   = w_cyc & m_stb_i[r_last];

    assign s_cyc_o = w_cyc;
    assign s_stb_o = w_stb;
    assign s_we_o  = w_cyc & m_we_i[r_last];
    assign s_adr_o = m_adr_i[w_sel*ADR_WIDTH +: ADR_WIDTH];
    assign s_dat_o = m_dat_i[w_sel*DAT_WIDTH +: DAT_WIDTH];
    assign m_dat_o = s_dat_i;
    assign gnt_o   = r_gnt;

    // Route the target ack only to the owner, and only for a live strobe.
    always_comb begin
        m_ack_o         = '0;
        m_ack_o[r_last] = s_ack_i & w_stb;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_tmo;
    logic          w_err;

    assign w_err = w_stb & ~s_ack_i & (r_tmo == CW'(TIMEOUT - 1));

    // Error pulse goes to the owner on the last unacked strobe cycle.
    always_comb begin
        m_err_o         = '0;
        m_err_o[r_last] = w_err;
    end

    // Count consecutive strobe cycles that have not been acked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo <= '0;
        end else if (!w_stb || s_ack_i) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign m_err_o = '0;
`endif

    // Arbitration FSM: grant in IDLE, hold ownership while the owner's cyc stays high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= IW'(NUM_REQ - 1);
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_BUSY;
                        r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_next;
                        r_last  <= w_next;
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i[r_last]) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (w_err) begin
                        r_state <= ST_ABORT;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    if (!m_cyc_i[r_last]) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/wishbone_arbiter_rr.md
Name: wishbone_arbiter_rr

Overview:
- Round-robin arbiter that shares one Wishbone B4 classic target between NUM_REQ controllers (e.g. several wishbone_ctrl_classic instances).
- Grants the bus per cycle (cyc): the granted requester keeps ownership while its cyc is high, so back-to-back locked transfers are allowed.
- The requester → target path is purely combinational once granted; arbitration is registered.
- Sits between the controller blocks and a single slave/interconnect port.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16).
- DAT_WIDTH, 8, data bus width.
- ADR_WIDTH, 8, address bus width.
- TIMEOUT, 16, stb-without-ack cycles before abort (only with WB_ARB_TIMEOUT_EN; ≥2).

Ports:
- clk_i  in  1  bus clock.
- rst_i  in  1  asynchronous active-high reset.
- m_cyc_i  in  NUM_REQ  per-requester cyc.
- m_stb_i  in  NUM_REQ  per-requester stb.
- m_we_i  in  NUM_REQ  per-requester we.
- m_adr_i  in  NUM_REQ*ADR_WIDTH  flattened addresses; requester k at [k*ADR_WIDTH +: ADR_WIDTH].
- m_dat_i  in  NUM_REQ*DAT_WIDTH  flattened write data, same packing.
- m_dat_o  out  DAT_WIDTH  read data, broadcast to all requesters (= s_dat_i).
- m_ack_o  out  NUM_REQ  ack, routed to granted requester only.
- m_err_o  out  NUM_REQ  timeout error pulse (tied 0 without feature).
- gnt_o  out  NUM_REQ  one-hot current grant (all zero when idle).
- s_cyc_o  out  1  target cyc.
- s_stb_o  out  1  target stb.
- s_we_o  out  1  target we.
- s_adr_o  out  ADR_WIDTH  target address.
- s_dat_o  out  DAT_WIDTH  target write data.
- s_dat_i  in  DAT_WIDTH  target read data.
- s_ack_i  in  1  target ack.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, gnt_o=0, last-grant pointer = NUM_REQ-1 (requester 0 wins first).
  - s_cyc_o, s_stb_o, s_we_o, m_ack_o and m_err_o all 0.
  - Any cycle in progress is dropped immediately, without ack.
- States: IDLE, BUSY, plus ABORT (only with the feature).
- IDLE:
  - If any m_cyc_i is high, on the next edge grant the first requester with cyc high, searching upward from last+1 and wrapping modulo NUM_REQ.
  - On that edge: gnt_o goes one-hot, pointer := grantee, state := BUSY.
  - Arbitration latency: exactly 1 clock from m_cyc_i rise to s_cyc_o rise.
- BUSY, granted index g:
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & m_cyc_i[g]; s_we_o = m_we_i[g] & s_cyc_o; s_adr_o/s_dat_o = slice g.
  - m_ack_o[g] = s_ack_i & s_stb_o; every other m_ack_o bit is 0.
  - Non-granted inputs are ignored.
  - When m_cyc_i[g] is low at an edge: state := IDLE, gnt_o := 0.
  - Minimum one idle cycle between different owners (no same-edge handover).
- Simultaneous requests: the round-robin order is strict. With all requesters continually requesting, grants rotate 0,1,2,3,0…; no requester waits more than NUM_REQ-1 tenures.
- A requester dropping cyc while not granted is simply not considered; no state is kept for it.
- s_ack_i arriving while s_stb_o=0 is ignored (not forwarded).
- In IDLE all s_* outputs are 0 (adr/dat are don't-care but driven with slice 0).

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears each cycle s_stb_o=0 or s_ack_i=1 and increments while s_stb_o=1 and s_ack_i=0.
  - On reaching TIMEOUT: m_err_o[g] pulses high for 1 cycle, state := ABORT, s_cyc_o/s_stb_o forced 0 from the next cycle.
  - ABORT holds the grant (masked) until m_cyc_i[g] is low, then goes to IDLE.
- Without the macro: no counter, no ABORT state, m_err_o tied 0; a hung target hangs the bus.

Test Plan:
- Reset, then m_cyc_i/m_stb_i[2]=1, we=1, adr=0x12, dat=0xA5; target acks 2 cycles later → s_cyc_o rises 1 clk after request, s_adr_o=0x12, s_dat_o=0xA5, m_ack_o=4'b0100 for exactly 1 cycle, gnt_o=0 one clk after cyc drops.
- All 4 requesters hold cyc, each does one read then drops cyc for 1 cycle → grant sequence 0,1,2,3,0; m_ack_o never reaches a non-granted port; m_dat_o equals s_dat_i.
- Requester 1 keeps cyc high for 3 back-to-back reads while requester 0 requests → requester 1 retains grant for all 3 acks; requester 0 granted 1 idle cycle after cyc[1] falls.
- Assert rst_i asynchronously mid-BUSY (between clock edges) → s_cyc_o, s_stb_o and gnt_o go to 0 immediately; after release, requester 0 wins a simultaneous 0/3 request.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=16, target never acks → m_err_o[g] pulses on the 16th stb cycle, s_cyc_o=0 next cycle, grant released after requester drops cyc; without the macro, s_stb_o stays high indefinitely.
